// File: rtl/arf_pkg.sv
// Shared encodings for the address register file: function codes and
// the default register index map.
package arf_pkg;

  localparam logic [1:0] FS_DEC  = 2'b00;
  localparam logic [1:0] FS_INC  = 2'b01;
  localparam logic [1:0] FS_LOAD = 2'b10;
  localparam logic [1:0] FS_CLR  = 2'b11;

  localparam int IDX_PC = 0;
  localparam int IDX_SP = 1;
  localparam int IDX_AR = 2;

endpackage

// File: rtl/addr_reg.sv
// One address register with step increment/decrement, load and clear.
// When BOUNDED, inc/dec that would leave [LO, HI] are blocked and reported.
module addr_reg
  import arf_pkg::*;
#(
  parameter int unsigned      WIDTH   = 16,
  parameter int unsigned      STEP    = 1,
  parameter bit               BOUNDED = 1'b0,
  parameter logic [WIDTH-1:0] LO      = '0,
  parameter logic [WIDTH-1:0] HI      = '1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       fun_sel,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] Q,
  output logic             Ovf_pulse,
  output logic             Unf_pulse
);

  localparam int unsigned      WX     = WIDTH + 1;
  localparam logic [WX-1:0]    STEP_X = WX'(STEP);
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  // Bound checks use one extra bit so the sum/difference cannot wrap.
  function automatic logic over_hi(input logic [WIDTH-1:0] v);
    return ({1'b0, v} + STEP_X) > {1'b0, HI};
  endfunction

  function automatic logic under_lo(input logic [WIDTH-1:0] v);
    return {1'b0, v} < ({1'b0, LO} + STEP_X);
  endfunction

  logic inc_blk;
  logic dec_blk;

  assign inc_blk   = BOUNDED && over_hi(Q);
  assign dec_blk   = BOUNDED && under_lo(Q);
  assign Ovf_pulse = en && (fun_sel == FS_INC) && inc_blk;
  assign Unf_pulse = en && (fun_sel == FS_DEC) && dec_blk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Q <= RST_VAL;
    end else if (en) begin
      case (fun_sel)
        FS_DEC:  if (!dec_blk) Q <= Q - STEP_W;
        FS_INC:  if (!inc_blk) Q <= Q + STEP_W;
        FS_LOAD: Q <= d;
        default: Q <= '0;
      endcase
    end
  end

endmodule

// File: rtl/addr_reg_file_gen.sv
// Address register file: NREG registers with masked multi-write, a bounded
// stack pointer with sticky overflow/underflow flags, and two read ports.
module addr_reg_file_gen
  import arf_pkg::*;
#(
  parameter int unsigned      WIDTH   = 16,
  parameter int unsigned      NREG    = 4,
  localparam int unsigned     SELW    = $clog2(NREG),
  parameter int unsigned      STEP    = 1,
  parameter int unsigned      SP_IDX  = IDX_SP,
  parameter logic [WIDTH-1:0] SP_MIN  = '0,
  parameter logic [WIDTH-1:0] SP_MAX  = '1,
  parameter logic [WIDTH-1:0] SP_RST  = '1,
  parameter bit               REG_OUT = 1'b0
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] I,
  input  logic [NREG-1:0]  RegSel,
  input  logic [1:0]       FunSel,
  input  logic [SELW-1:0]  OutCSel,
  input  logic [SELW-1:0]  OutDSel,
  input  logic             FlagClr,
  output logic [WIDTH-1:0] OutC,
  output logic [WIDTH-1:0] OutD,
  output logic             SpOvf,
  output logic             SpUnf
);

  logic [WIDTH-1:0] q [NREG];
  logic [NREG-1:0]  ovf_v;
  logic [NREG-1:0]  unf_v;

  for (genvar i = 0; i < NREG; i++) begin : g_reg
    addr_reg #(
      .WIDTH  (WIDTH),
      .STEP   (STEP),
      .BOUNDED(i == SP_IDX),
      .LO     (SP_MIN),
      .HI     (SP_MAX),
      .RST_VAL((i == SP_IDX) ? SP_RST : '0)
    ) u_reg (
      .clk      (Clock),
      .rst_n    (Reset_n),
      .en       (RegSel[i]),
      .fun_sel  (FunSel),
      .d        (I),
      .Q        (q[i]),
      .Ovf_pulse(ovf_v[i]),
      .Unf_pulse(unf_v[i])
    );
  end

  // A blocked step in the same cycle as FlagClr keeps the flag set.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      SpOvf <= 1'b0;
      SpUnf <= 1'b0;
    end else begin
      if (|ovf_v)       SpOvf <= 1'b1;
      else if (FlagClr) SpOvf <= 1'b0;
      if (|unf_v)       SpUnf <= 1'b1;
      else if (FlagClr) SpUnf <= 1'b0;
    end
  end

  // Out-of-range selects match no register and read as zero.
  logic [WIDTH-1:0] rd_c;
  logic [WIDTH-1:0] rd_d;

  always_comb begin
    rd_c = '0;
    rd_d = '0;
    for (int i = 0; i < NREG; i++) begin
      if (OutCSel == SELW'(i)) rd_c = q[i];
      if (OutDSel == SELW'(i)) rd_d = q[i];
    end
  end

  if (REG_OUT) begin : g_reg_out
    logic [WIDTH-1:0] out_c_p1;
    logic [WIDTH-1:0] out_d_p1;

    // p0 -> p1: sample the pre-update register contents.
    always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
        out_c_p1 <= '0;
        out_d_p1 <= '0;
      end else begin
        out_c_p1 <= rd_c;
        out_d_p1 <= rd_d;
      end
    end

    assign OutC = out_c_p1;
    assign OutD = out_d_p1;
  end else begin : g_comb_out
    assign OutC = rd_c;
    assign OutD = rd_d;
  end

endmodule

// File: tb/tb_addr_reg_file_gen.sv
// Bench for addr_reg_file_gen: three configurations driven by shared inputs,
// directed vector table, corner sequences and random traffic vs. a model.
module tb_addr_reg_file_gen;
  import arf_pkg::*;

  logic        Clock   = 1'b0;
  logic        Reset_n = 1'b0;
  logic        FlagClr = 1'b0;
  logic [15:0] I       = '0;
  logic [3:0]  RegSel  = '0;
  logic [1:0]  FunSel  = '0;
  logic [1:0]  OutCSel = '0;
  logic [1:0]  OutDSel = '0;

  logic [15:0] oc [3];
  logic [15:0] od [3];
  logic        ov [3];
  logic        un [3];

  always #5 Clock = ~Clock;

  addr_reg_file_gen u0 (
    .Clock(Clock), .Reset_n(Reset_n), .I(I), .RegSel(RegSel), .FunSel(FunSel),
    .OutCSel(OutCSel), .OutDSel(OutDSel), .FlagClr(FlagClr),
    .OutC(oc[0]), .OutD(od[0]), .SpOvf(ov[0]), .SpUnf(un[0])
  );

  addr_reg_file_gen #(
    .STEP(2), .SP_MIN(16'h0100), .SP_MAX(16'h01FF), .SP_RST(16'h01FF)
  ) u1 (
    .Clock(Clock), .Reset_n(Reset_n), .I(I), .RegSel(RegSel), .FunSel(FunSel),
    .OutCSel(OutCSel), .OutDSel(OutDSel), .FlagClr(FlagClr),
    .OutC(oc[1]), .OutD(od[1]), .SpOvf(ov[1]), .SpUnf(un[1])
  );

  addr_reg_file_gen #(
    .NREG(3), .REG_OUT(1'b1)
  ) u2 (
    .Clock(Clock), .Reset_n(Reset_n), .I(I), .RegSel(RegSel[2:0]), .FunSel(FunSel),
    .OutCSel(OutCSel), .OutDSel(OutDSel), .FlagClr(FlagClr),
    .OutC(oc[2]), .OutD(od[2]), .SpOvf(ov[2]), .SpUnf(un[2])
  );

  // Reference model: plain integers per configuration.
  int unsigned cstep [3] = '{1, 2, 1};
  int unsigned cmin  [3] = '{0, 'h100, 0};
  int unsigned cmax  [3] = '{'hFFFF, 'h1FF, 'hFFFF};
  int unsigned crst  [3] = '{'hFFFF, 'h1FF, 'hFFFF};
  int unsigned cnreg [3] = '{4, 4, 3};
  bit          cregout [3] = '{0, 0, 1};

  int unsigned mreg [3][4];
  bit          movf [3];
  bit          munf [3];
  int unsigned mout_c [3];
  int unsigned mout_d [3];

  int total = 0;
  int bad   = 0;

  function automatic int unsigned rd(input int k, input int sel);
    return (sel < int'(cnreg[k])) ? mreg[k][sel] : 0;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) mreg[k][i] = 0;
      mreg[k][1] = crst[k];
      movf[k] = 0;
      munf[k] = 0;
      mout_c[k] = 0;
      mout_d[k] = 0;
    end
  endfunction

  function automatic void model_edge();
    for (int k = 0; k < 3; k++) begin
      bit os;
      bit us;
      os = 0;
      us = 0;
      if (cregout[k]) begin
        mout_c[k] = rd(k, int'(OutCSel));
        mout_d[k] = rd(k, int'(OutDSel));
      end
      for (int i = 0; i < int'(cnreg[k]); i++) begin
        if (RegSel[i]) begin
          int unsigned v;
          v = mreg[k][i];
          case (FunSel)
            FS_LOAD: v = I;
            FS_CLR:  v = 0;
            FS_INC: begin
              if (i == 1) begin
                if (v + cstep[k] > cmax[k]) os = 1;
                else v = v + cstep[k];
              end else v = (v + cstep[k]) % 65536;
            end
            default: begin
              if (i == 1) begin
                if (v < cmin[k] + cstep[k]) us = 1;
                else v = v - cstep[k];
              end else v = (v + 65536 - cstep[k]) % 65536;
            end
          endcase
          mreg[k][i] = v;
        end
      end
      if (os) movf[k] = 1; else if (FlagClr) movf[k] = 0;
      if (us) munf[k] = 1; else if (FlagClr) munf[k] = 0;
    end
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    for (int k = 0; k < 3; k++) begin
      int unsigned ec;
      int unsigned ed;
      ec = cregout[k] ? mout_c[k] : rd(k, int'(OutCSel));
      ed = cregout[k] ? mout_d[k] : rd(k, int'(OutDSel));
      cmp($sformatf("%s u%0d.OutC", tag, k), 32'(oc[k]), ec);
      cmp($sformatf("%s u%0d.OutD", tag, k), 32'(od[k]), ed);
      cmp($sformatf("%s u%0d.SpOvf", tag, k), 32'(ov[k]), 32'(movf[k]));
      cmp($sformatf("%s u%0d.SpUnf", tag, k), 32'(un[k]), 32'(munf[k]));
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive(input logic [3:0] rs, input logic [1:0] fs, input logic [15:0] d,
                       input logic [1:0] cs, input logic [1:0] ds, input logic fc);
    RegSel = rs; FunSel = fs; I = d; OutCSel = cs; OutDSel = ds; FlagClr = fc;
  endtask

  typedef struct {
    logic [3:0]  rs;
    logic [1:0]  fs;
    logic [15:0] d;
    logic [1:0]  cs;
    logic [1:0]  ds;
    logic        fc;
    logic [15:0] ec;
    logic [15:0] ed;
    logic        eo;
    logic        eu;
  } vec_t;

  vec_t tbl [12];

  initial begin
    tbl[0]  = '{4'b0101, FS_LOAD, 16'h1234, 2'd0, 2'd2, 1'b0, 16'h1234, 16'h1234, 1'b0, 1'b0};
    tbl[1]  = '{4'b0101, FS_INC,  16'h0000, 2'd0, 2'd1, 1'b0, 16'h1235, 16'hFFFF, 1'b0, 1'b0};
    tbl[2]  = '{4'b0001, FS_LOAD, 16'hFFFF, 2'd0, 2'd2, 1'b0, 16'hFFFF, 16'h1235, 1'b0, 1'b0};
    tbl[3]  = '{4'b0001, FS_INC,  16'h0000, 2'd0, 2'd2, 1'b0, 16'h0000, 16'h1235, 1'b0, 1'b0};
    tbl[4]  = '{4'b0100, FS_CLR,  16'h0000, 2'd2, 2'd0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tbl[5]  = '{4'b0100, FS_DEC,  16'h0000, 2'd2, 2'd1, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0};
    tbl[6]  = '{4'b0010, FS_INC,  16'h0000, 2'd1, 2'd3, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 1'b0};
    tbl[7]  = '{4'b0000, FS_DEC,  16'h0000, 2'd1, 2'd0, 1'b1, 16'hFFFF, 16'h0000, 1'b0, 1'b0};
    tbl[8]  = '{4'b0010, FS_CLR,  16'h0000, 2'd1, 2'd2, 1'b0, 16'h0000, 16'hFFFF, 1'b0, 1'b0};
    tbl[9]  = '{4'b0010, FS_DEC,  16'h0000, 2'd1, 2'd2, 1'b0, 16'h0000, 16'hFFFF, 1'b0, 1'b1};
    tbl[10] = '{4'b1111, FS_LOAD, 16'h00A5, 2'd3, 2'd1, 1'b0, 16'h00A5, 16'h00A5, 1'b0, 1'b1};
    tbl[11] = '{4'b0010, FS_DEC,  16'h0000, 2'd1, 2'd0, 1'b1, 16'h00A4, 16'h00A5, 1'b0, 1'b0};

    // Reset state
    model_reset();
    #12;
    Reset_n = 1'b1;
    drive(4'b0000, FS_DEC, 16'h0000, 2'd0, 2'd1, 1'b0);
    #1;
    cmp("reset u0.OutC", 32'(oc[0]), 32'h0000);
    cmp("reset u0.OutD", 32'(od[0]), 32'hFFFF);
    cmp("reset u0.SpOvf", 32'(ov[0]), 32'h0);
    cmp("reset u0.SpUnf", 32'(un[0]), 32'h0);
    cmp("reset u2.OutC", 32'(oc[2]), 32'h0000);
    check_model("reset");

    // Directed table on the default configuration
    for (int n = 0; n < 12; n++) begin
      drive(tbl[n].rs, tbl[n].fs, tbl[n].d, tbl[n].cs, tbl[n].ds, tbl[n].fc);
      tick();
      cmp($sformatf("vec%0d u0.OutC", n), 32'(oc[0]), 32'(tbl[n].ec));
      cmp($sformatf("vec%0d u0.OutD", n), 32'(od[0]), 32'(tbl[n].ed));
      cmp($sformatf("vec%0d u0.SpOvf", n), 32'(ov[0]), 32'(tbl[n].eo));
      cmp($sformatf("vec%0d u0.SpUnf", n), 32'(un[0]), 32'(tbl[n].eu));
      check_model($sformatf("vec%0d", n));
    end

    // Bounded SP with STEP=2 (u1)
    drive(4'b0010, FS_LOAD, 16'h01FE, 2'd1, 2'd0, 1'b0); tick();
    drive(4'b0010, FS_INC,  16'h0000, 2'd1, 2'd0, 1'b0); tick();
    cmp("sp_ovf u1.OutC", 32'(oc[1]), 32'h01FE);
    cmp("sp_ovf u1.SpOvf", 32'(ov[1]), 32'h1);
    check_model("sp_ovf");
    drive(4'b0010, FS_INC,  16'h0000, 2'd1, 2'd0, 1'b1); tick();
    cmp("clr_vs_set u1.SpOvf", 32'(ov[1]), 32'h1);
    cmp("clr_vs_set u1.SpUnf", 32'(un[1]), 32'h0);
    check_model("clr_vs_set");
    drive(4'b0010, FS_LOAD, 16'h0101, 2'd1, 2'd0, 1'b0); tick();
    drive(4'b0010, FS_DEC,  16'h0000, 2'd1, 2'd0, 1'b0); tick();
    cmp("sp_unf u1.OutC", 32'(oc[1]), 32'h0101);
    cmp("sp_unf u1.SpUnf", 32'(un[1]), 32'h1);
    check_model("sp_unf");
    drive(4'b0010, FS_LOAD, 16'h0150, 2'd1, 2'd0, 1'b0); tick();
    drive(4'b0010, FS_DEC,  16'h0000, 2'd1, 2'd0, 1'b0); tick();
    cmp("sp_dec u1.OutC", 32'(oc[1]), 32'h014E);
    check_model("sp_dec");

    // Registered read ports (u2)
    drive(4'b0001, FS_CLR,  16'h0000, 2'd0, 2'd1, 1'b0); tick();
    drive(4'b0001, FS_LOAD, 16'h0042, 2'd0, 2'd1, 1'b0); tick();
    cmp("regout_old u2.OutC", 32'(oc[2]), 32'h0000);
    check_model("regout_old");
    drive(4'b0000, FS_LOAD, 16'h0000, 2'd0, 2'd1, 1'b0); tick();
    cmp("regout_new u2.OutC", 32'(oc[2]), 32'h0042);
    check_model("regout_new");
    drive(4'b0000, FS_LOAD, 16'h0000, 2'd3, 2'd0, 1'b0); tick();
    cmp("regout_oob u2.OutC", 32'(oc[2]), 32'h0000);
    check_model("regout_oob");

    // Asynchronous reset between edges during increments
    drive(4'b1111, FS_INC, 16'h0000, 2'd0, 2'd1, 1'b0);
    tick();
    tick();
    #3;
    Reset_n = 1'b0;
    #1;
    model_reset();
    cmp("areset u0.OutC", 32'(oc[0]), 32'h0000);
    cmp("areset u0.OutD", 32'(od[0]), 32'hFFFF);
    cmp("areset u2.OutD", 32'(od[2]), 32'h0000);
    check_model("areset");
    #2;
    Reset_n = 1'b1;
    #1;
    check_model("areset_rel");

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      RegSel = 4'($urandom);
      if ($urandom_range(0, 3) == 0) FunSel = 2'($urandom);
      else FunSel = ($urandom_range(0, 1) == 1) ? FS_INC : FS_DEC;
      case ($urandom_range(0, 3))
        0: I = 16'($urandom);
        1: I = 16'($urandom_range(16'h00F0, 16'h0210));
        2: I = 16'hFFFF - 16'($urandom_range(0, 3));
        default: I = 16'($urandom_range(0, 3));
      endcase
      OutCSel = 2'($urandom);
      OutDSel = 2'($urandom);
      FlagClr = ($urandom_range(0, 7) == 0);
      tick();
      check_model($sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
